fifo_bit_packer: RTL and testbench

Write-side front end for the Toeplitz datapath's 32-bit word FIFO. It accepts a bit-serial raw-key stream with a valid/ready handshake and packs bits MSB-first into 32-bit words. At frame end it flushes a zero-padded partial word. Completed words are pushed into the FIFO through a wr_en/full interface; the FIFO's read side (rd_en/fifo_out/fifo_empty) feeds the hash engine.

---
 rtl/fifo_bit_packer.sv | 89 ++++++++
 tb/tb_fifo_bit_packer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_bit_packer.sv
// fifo_bit_packer: packs a bit-serial valid/ready stream MSB-first into 32-bit words for a word FIFO.
//   clk_in      rising-edge system clock
//   rst         synchronous active-low reset
//   bit_in      serial data bit, qualified by bit_valid
//   bit_valid   bit_in/bit_last qualifier
//   bit_last    final bit of a frame; a partial word is flushed left-justified, zero-padded
//   bit_ready   a bit can be accepted this cycle
//   fifo_din    word to the FIFO, meaningful while fifo_wr_en=1
//   fifo_wr_en  FIFO write strobe
//   fifo_full   registered FIFO full flag
//   frame_done  one-cycle pulse after the last word of a frame is written
//   frame_words words written in the last completed frame (saturating), held until the next frame
module fifo_bit_packer #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              bit_last,
    output logic              bit_ready,
    output logic [WORD_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_words
);
    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    // The top shift-register bit is never needed: on the 32nd bit the word is taken from the shift input directly.
    logic [WORD_W-2:0] sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] hold_word_q, hold_word_d;
    logic              hold_valid_q, hold_valid_d;
    logic              hold_last_q, hold_last_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  frame_words_q, frame_words_d;
    logic              frame_done_q, frame_done_d;
    logic              accept, load;
    logic [WORD_W-1:0] shifted;
    logic [CNT_W-1:0]  fcnt_inc;

    // Stall every bit while a held word is blocked; gate with rst so nothing moves during reset.
    assign bit_ready   = rst && !(hold_valid_q && fifo_full);
    assign fifo_wr_en  = rst && hold_valid_q && !fifo_full;
    assign fifo_din    = hold_word_q;
    assign frame_done  = frame_done_q;
    assign frame_words = frame_words_q;

    always_comb begin
        accept        = bit_valid && bit_ready;
        shifted       = {sr_q, bit_in};
        load          = accept && (cnt_q == LAST || bit_last);
        fcnt_inc      = &fcnt_q ? fcnt_q : fcnt_q + 1'b1;
        sr_d          = accept ? shifted[WORD_W-2:0] : sr_q;
        cnt_d         = load ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
        // Shifting by 31-cnt left-justifies an n-bit partial word and pushes stale bits out the top.
        hold_word_d   = load ? shifted << (LAST - cnt_q) : hold_word_q;
        hold_valid_d  = load || (hold_valid_q && !fifo_wr_en);
        hold_last_d   = load ? bit_last : hold_last_q;
        fcnt_d        = fifo_wr_en ? (hold_last_q ? '0 : fcnt_inc) : fcnt_q;
        frame_words_d = (fifo_wr_en && hold_last_q) ? fcnt_inc : frame_words_q;
        frame_done_d  = fifo_wr_en && hold_last_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sr_q          <= '0;
            cnt_q         <= '0;
            hold_word_q   <= '0;
            hold_valid_q  <= 1'b0;
            hold_last_q   <= 1'b0;
            fcnt_q        <= '0;
            frame_words_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            hold_word_q   <= hold_word_d;
            hold_valid_q  <= hold_valid_d;
            hold_last_q   <= hold_last_d;
            fcnt_q        <= fcnt_d;
            frame_words_q <= frame_words_d;
            frame_done_q  <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_fifo_bit_packer.sv
// tb_fifo_bit_packer: table-driven and directed checks of the bit packer against hand-computed words.
module tb_fifo_bit_packer;
    logic        clk_in = 1'b0, rst = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, bit_last = 1'b0, fifo_full = 1'b0;
    logic        bit_ready, fifo_wr_en, frame_done;
    logic [31:0] fifo_din;
    logic [15:0] frame_words;
    int          n_cmp = 0, n_bad = 0, stalls = 0, done_cnt = 0;
    logic [31:0] wq[$];

    typedef struct {
        int          nbits;
        logic [63:0] data;
        logic        last;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        int          ndone;
        logic [15:0] fw;
    } vec_t;

    vec_t vt[8];

    always #5 clk_in = ~clk_in;

    fifo_bit_packer #(.WORD_W(32), .CNT_W(16)) dut (
        .clk_in(clk_in), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last),
        .bit_ready(bit_ready), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .frame_done(frame_done), .frame_words(frame_words)
    );

    always @(negedge clk_in) begin
        if (fifo_wr_en) wq.push_back(fifo_din);
        if (frame_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic l);
        logic acc;
        bit_in = b;
        bit_valid = 1'b1;
        bit_last = l;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_in);
            acc = bit_ready;
            @(posedge clk_in);
            #1;
            if (acc) begin
                bit_valid = 1'b0;
                bit_last = 1'b0;
                return;
            end
            stalls++;
        end
        chk("send_timeout", 64'd1, 64'd0);
        bit_valid = 1'b0;
        bit_last = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] d, input int n, input logic l);
        for (int i = 0; i < n; i++) send_bit(d[n-1-i], l && (i == n - 1));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    initial begin
        int base, d0, s0, bad_wr, bad_rdy, bad_din;
        vt[0] = '{8,  64'hC3,               1'b1, 1, 32'hC3000000, 32'h0,        1, 16'd1};
        vt[1] = '{40, 64'hDEADBEEF81,       1'b1, 2, 32'hDEADBEEF, 32'h81000000, 1, 16'd2};
        vt[2] = '{32, 64'hA5A50F0F,         1'b0, 1, 32'hA5A50F0F, 32'h0,        0, 16'd2};
        vt[3] = '{4,  64'hB,                1'b1, 1, 32'hB0000000, 32'h0,        1, 16'd2};
        vt[4] = '{64, 64'h0123456789ABCDEF, 1'b0, 2, 32'h01234567, 32'h89ABCDEF, 0, 16'd2};
        vt[5] = '{31, 64'h7FFFFFFF,         1'b1, 1, 32'hFFFFFFFE, 32'h0,        1, 16'd3};
        vt[6] = '{1,  64'h1,                1'b1, 1, 32'h80000000, 32'h0,        1, 16'd1};
        vt[7] = '{32, 64'h00000001,         1'b1, 1, 32'h00000001, 32'h0,        1, 16'd1};

        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_bit_ready", bit_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_words", frame_words, 0);
        chk("rst_fifo_din", fifo_din, 0);
        @(posedge clk_in);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 8; k++) begin
            base = wq.size();
            d0 = done_cnt;
            s0 = stalls;
            send_bits(vt[k].data, vt[k].nbits, vt[k].last);
            settle();
            chk($sformatf("v%0d_nwrites", k), 64'(wq.size() - base), 64'(vt[k].nw));
            if (wq.size() >= base + vt[k].nw) begin
                chk($sformatf("v%0d_word0", k), wq[base], vt[k].w0);
                if (vt[k].nw > 1) chk($sformatf("v%0d_word1", k), wq[base+1], vt[k].w1);
            end
            chk($sformatf("v%0d_done", k), 64'(done_cnt - d0), 64'(vt[k].ndone));
            chk($sformatf("v%0d_frame_words", k), frame_words, vt[k].fw);
            chk($sformatf("v%0d_stalls", k), 64'(stalls - s0), 0);
        end

        d0 = done_cnt;
        send_bits(64'h0F0F1234, 32, 1'b0);
        @(negedge clk_in);
        chk("lat_wr_en", fifo_wr_en, 1);
        chk("lat_din", fifo_din, 32'h0F0F1234);
        @(negedge clk_in);
        chk("lat_single", fifo_wr_en, 0);
        settle();
        chk("lat_no_done", 64'(done_cnt - d0), 0);

        base = wq.size();
        fifo_full = 1'b1;
        send_bits(64'h12345678, 32, 1'b0);
        bit_in = 1'b1;
        bit_valid = 1'b1;
        bad_wr = 0;
        bad_rdy = 0;
        bad_din = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (fifo_wr_en) bad_wr++;
            if (bit_ready) bad_rdy++;
            if (fifo_din !== 32'h12345678) bad_din++;
        end
        chk("stall_wr_en", 64'(bad_wr), 0);
        chk("stall_ready", 64'(bad_rdy), 0);
        chk("stall_din_held", 64'(bad_din), 0);
        chk("stall_no_write", 64'(wq.size() - base), 0);
        @(posedge clk_in);
        #1;
        fifo_full = 1'b0;
        send_bits(64'h9ABCDEF0, 32, 1'b0);
        settle();
        chk("stall_nwrites", 64'(wq.size() - base), 2);
        if (wq.size() >= base + 2) begin
            chk("stall_word0", wq[base], 32'h12345678);
            chk("stall_word1", wq[base+1], 32'h9ABCDEF0);
        end

        base = wq.size();
        fifo_full = 1'b1;
        send_bits(64'h55AA55AA, 32, 1'b0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk_in);
        chk("rst_hold_wr_en", fifo_wr_en, 0);
        chk("rst_hold_ready", bit_ready, 0);
        @(posedge clk_in);
        #1;
        rst = 1'b1;
        @(negedge clk_in);
        chk("rst_after_wr_en", fifo_wr_en, 0);
        send_bits(64'hABCDE, 20, 1'b0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        @(negedge clk_in);
        chk("rst_mid_frame_words", frame_words, 0);
        chk("rst_mid_din", fifo_din, 0);
        @(posedge clk_in);
        #1;
        rst = 1'b1;
        send_bits(64'hFFFF0000, 32, 1'b0);
        settle();
        chk("rst_nwrites", 64'(wq.size() - base), 1);
        if (wq.size() >= base + 1) chk("rst_word", wq[base], 32'hFFFF0000);
        chk("rst_frame_words_kept", frame_words, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
